cubehash_padder: RTL and testbench
==================================

Name: cubehash_padder

Overview:
- Upstream stage of the CubeHash core. It accepts a raw message byte stream and appends CubeHash padding.
- Padding is one 0x80 byte, then 0x00 bytes until the total length is a multiple of BLOCK_BYTES.
- Emits a byte stream with a valid/ready handshake. The downstream byte packer assembles the stream into 256-bit message blocks.
- Reports the number of blocks produced per message and a one-cycle end-of-message pulse for the controller.

Parameters:
BLOCK_BYTES, 32, bytes per message block; must be a power of two.
CNT_W, 16, width of the per-message block counter.

Ports:
clk  input  1  rising-edge clock
rst_p  input  1  reset, asynchronous, active-high
in_valid  input  1  in_byte is valid this cycle
in_byte  input  8  message byte
in_last  input  1  qualifies in_valid; marks the final message byte
in_empty  input  1  one-cycle pulse: zero-length message; only honoured in S_PASS
in_ready  output  1  padder accepts a byte this cycle
out_valid  output  1  out_byte valid
out_byte  output  8  padded stream byte
out_ready  input  1  downstream accepts out_byte
out_final  output  1  high with the last padded byte of a message
pad_done  output  1  one-cycle pulse after the final byte transfers
blocks  output  CNT_W  blocks emitted for the last message; valid from pad_done until the next pad_done
err  output  1  sticky: block counter saturated, or in_empty while busy

Behaviour:
- Reset values (async, rst_p=1):
  - state = S_PASS.
  - out_valid, out_final, pad_done, err = 0; out_byte = 0x00; blocks = 0.
  - Internal position counter pos (log2(BLOCK_BYTES) bits) = 0; block counter = 0.
  - Reset mid-message drops all in-flight bytes.
- Output register:
  - A "load" occurs when the state supplies a byte and (!out_valid || out_ready).
  - On load: out_valid <= 1, out_byte updated, pos <= pos+1 (wraps mod BLOCK_BYTES).
  - On each wrap to 0, the block counter increments.
  - If out_ready && out_valid and there is no load, out_valid <= 0.
  - Latency: input byte to out_valid is 1 cycle.
- States:
  - S_PASS:
    - in_ready = !out_valid || out_ready.
    - An accepted byte loads directly.
    - If in_last is set, go to S_PAD80.
    - If in_empty is set, go to S_PAD80 with nothing loaded.
  - S_PAD80:
    - in_ready = 0.
    - On a free slot, load 0x80.
    - If the load makes pos wrap to 0, set out_final and go to S_DRAIN; else go to S_ZERO.
  - S_ZERO:
    - Load 0x00 each free slot.
    - The load that wraps pos to 0 sets out_final and goes to S_DRAIN.
  - S_DRAIN:
    - Wait until the out_final byte transfers (out_valid && out_ready && out_final).
    - Next cycle: pad_done = 1, blocks <= block counter, block counter and pos <= 0, out_final cleared, return to S_PASS.
- Boundary rules:
  - If the message length L is a multiple of BLOCK_BYTES (including L=0), one extra full block is produced: 0x80 followed by BLOCK_BYTES-1 zeros.
  - Total output length = (floor(L/BLOCK_BYTES)+1) * BLOCK_BYTES.
- Backpressure: out_byte and out_final hold stable while out_valid && !out_ready. No byte is lost or duplicated.
- Conflicts and errors:
  - in_valid together with in_empty: in_empty takes priority and the byte is not accepted (in_ready is forced 0 that cycle).
  - in_empty outside S_PASS is ignored and sets err.
  - The block counter saturates at 2^CNT_W-1 and sets err; err clears only on reset.
- in_valid while in_ready=0 is plain backpressure. The source holds its byte; this is not an error.

Test Plan:
- L=3, bytes 0x61,0x62,0x63, out_ready=1 always -> 32 bytes out: 61 62 63 80 followed by 28×00. out_final on byte 32; pad_done 1 cycle later; blocks=1.
- L=32 (bytes 0x00..0x1F) -> 64 bytes out: the 32 data bytes, then 80 and 31×00; blocks=2; in_ready low from the cycle after in_last until pad_done.
- in_empty pulse, no data -> 80 followed by 31×00; blocks=1; err=0.
- L=31 with out_ready toggling 1/0 each cycle -> 32 bytes out, the last being 0x80. out_byte stable during every stall; exactly 32 transfers.
- rst_p asserted asynchronously mid-S_ZERO, then released, then a new message L=1 (0xAA) -> outputs go to 0 immediately without waiting for a clock; the new output is AA 80 followed by 30×00; blocks=1.
- CNT_W=2 build, L=120 -> blocks saturates at 3 and err=1 sticky; in_empty sent during S_ZERO also sets err.

Source files
------------

// File: rtl/cubehash_padder.sv
// CubeHash message padder: passes message bytes through, then appends 0x80 and
// zero fill up to a BLOCK_BYTES boundary, counting the blocks emitted per message.
module cubehash_padder #(
  parameter int unsigned BLOCK_BYTES = 32,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  input  logic             in_empty,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_byte,
  input  logic             out_ready,
  output logic             out_final,
  output logic             pad_done,
  output logic [CNT_W-1:0] blocks,
  output logic             err
);

  localparam int unsigned POS_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;

  typedef enum logic [1:0] {
    S_PASS,
    S_PAD80,
    S_ZERO,
    S_DRAIN
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  logic               r_out_valid;
  logic [7:0]         r_out_byte;
  logic               r_out_final;
  logic               r_pad_done;
  logic [CNT_W-1:0]   r_blocks;
  logic [CNT_W-1:0]   r_blk_cnt;
  logic               r_err;
  logic [POS_W-1:0]   r_pos;

  logic               w_slot;
  logic               w_xfer;
  logic               w_load;
  logic [7:0]         w_load_byte;
  logic               w_in_ready;
  logic [POS_W-1:0]   w_pos_next;
  logic               w_wrap;
  logic               w_set_final;
  logic               w_done;

  assign w_slot      = !r_out_valid || out_ready;
  assign w_xfer      = r_out_valid && out_ready;
  assign w_pos_next  = r_pos + POS_W'(1);
  assign w_wrap      = w_load && (w_pos_next == '0);
  // Only padding bytes can close a message; a data byte filling a block never does.
  assign w_set_final = w_wrap && (r_state != S_PASS);
  assign w_done      = (r_state == S_DRAIN) && w_xfer && r_out_final;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_state <= S_PASS;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_PASS: begin
        if (in_empty) begin
          w_state_next = S_PAD80;
        end else if (in_valid && w_in_ready && in_last) begin
          w_state_next = S_PAD80;
        end
      end
      S_PAD80: begin
        if (w_slot) begin
          w_state_next = w_wrap ? S_DRAIN : S_ZERO;
        end
      end
      S_ZERO: begin
        if (w_wrap) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_done) begin
          w_state_next = S_PASS;
        end
      end
      default: w_state_next = S_PASS;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_load      = 1'b0;
    w_load_byte = 8'h00;
    unique case (r_state)
      S_PASS: begin
        // in_empty wins over a coincident data byte, which stays with the source.
        w_in_ready  = w_slot && !in_empty;
        w_load      = in_valid && w_in_ready;
        w_load_byte = in_byte;
      end
      S_PAD80: begin
        w_load      = w_slot;
        w_load_byte = 8'h80;
      end
      S_ZERO: begin
        w_load      = w_slot;
        w_load_byte = 8'h00;
      end
      default: begin
        w_load      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_out_valid <= 1'b0;
      r_out_byte  <= 8'h00;
      r_out_final <= 1'b0;
      r_pad_done  <= 1'b0;
      r_blocks    <= '0;
      r_blk_cnt   <= '0;
      r_err       <= 1'b0;
      r_pos       <= '0;
    end else begin
      r_pad_done <= w_done;
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_byte  <= w_load_byte;
        r_pos       <= w_pos_next;
        if (w_set_final) begin
          r_out_final <= 1'b1;
        end
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
      if (w_done) begin
        r_out_final <= 1'b0;
        r_pos       <= '0;
        r_blk_cnt   <= '0;
        r_blocks    <= r_blk_cnt;
      end else if (w_wrap) begin
        if (r_blk_cnt == '1) begin
          r_err <= 1'b1;
        end else begin
          r_blk_cnt <= r_blk_cnt + CNT_W'(1);
        end
      end
      if (in_empty && (r_state != S_PASS)) begin
        r_err <= 1'b1;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_byte  = r_out_byte;
  assign out_final = r_out_final;
  assign pad_done  = r_pad_done;
  assign blocks    = r_blocks;
  assign err       = r_err;

endmodule

// File: tb/tb_cubehash_padder.sv
// Directed bench for cubehash_padder: expected padded bytes are queued as each
// message is driven and checked as the padder hands them downstream.
module tb_cubehash_padder;

  localparam int BB = 32;

  logic        clk = 1'b0;
  logic        rst_p = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_last = 1'b0;
  logic        in_empty = 1'b0;
  logic        toggle_en = 1'b0;
  logic        tog = 1'b0;
  logic        out_ready;

  logic        in_ready, out_valid, out_final, pad_done, err;
  logic [7:0]  out_byte;
  logic [15:0] blocks;

  logic        s_in_ready, s_out_valid, s_out_final, s_pad_done, s_err;
  logic [7:0]  s_out_byte;
  logic [1:0]  s_blocks;

  typedef struct packed {
    logic [7:0] b;
    logic       f;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  logic       stalled = 1'b0;
  logic [7:0] held_b = 8'h00;
  logic       held_f = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;
  assign out_ready = toggle_en ? tog : 1'b1;

  cubehash_padder #(.BLOCK_BYTES(BB), .CNT_W(16)) dut (
    .clk(clk), .rst_p(rst_p), .in_valid(in_valid), .in_byte(in_byte),
    .in_last(in_last), .in_empty(in_empty), .in_ready(in_ready),
    .out_valid(out_valid), .out_byte(out_byte), .out_ready(out_ready),
    .out_final(out_final), .pad_done(pad_done), .blocks(blocks), .err(err)
  );

  cubehash_padder #(.BLOCK_BYTES(BB), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_p(rst_p), .in_valid(in_valid), .in_byte(in_byte),
    .in_last(in_last), .in_empty(in_empty), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_byte(s_out_byte), .out_ready(out_ready),
    .out_final(s_out_final), .pad_done(s_pad_done), .blocks(s_blocks), .err(s_err)
  );

  always @(negedge clk) begin
    exp_t e;
    if (rst_p) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        n_vec++;
        assert (out_valid === 1'b1 && out_byte === held_b && out_final === held_f) else begin
          n_bad++;
          $error("FAIL stall_hold: observed v=%b b=%h f=%b expected v=1 b=%h f=%b",
                 out_valid, out_byte, out_final, held_b, held_f);
        end
      end
      stalled = (out_valid === 1'b1) && (out_ready === 1'b0);
      held_b  = out_byte;
      held_f  = out_final;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_vec++;
        assert (q.size() != 0) else begin
          n_bad++;
          $error("FAIL extra_byte: observed %h expected no transfer", out_byte);
        end
        if (q.size() != 0) begin
          e = q.pop_front();
          n_vec++;
          assert (out_byte === e.b && out_final === e.f) else begin
            n_bad++;
            $error("FAIL out_byte: observed %h/final=%b expected %h/final=%b",
                   out_byte, out_final, e.b, e.f);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_pad(input int len);
    int extra;
    extra = BB - (len % BB);
    for (int i = 0; i < extra; i++) begin
      q.push_back('{b: (i == 0) ? 8'h80 : 8'h00, f: (i == extra - 1)});
    end
  endtask

  task automatic send_msg(input int len, input logic [7:0] base);
    int t;
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_byte  = base + 8'(i);
      in_last  = (i == len - 1);
      q.push_back('{b: base + 8'(i), f: 1'b0});
      t = 0;
      @(negedge clk);
      while (in_ready !== 1'b1 && t < 1000) begin
        t++;
        @(negedge clk);
      end
      chk("accept_timeout", (t < 1000), 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    push_pad(len);
  endtask

  task automatic wait_done(input int exp_blocks, input logic exp_err);
    int   t;
    logic rdy_bad;
    t = 0;
    rdy_bad = 1'b0;
    @(negedge clk);
    while (pad_done !== 1'b1 && t < 3000) begin
      if (in_ready !== 1'b0) rdy_bad = 1'b1;
      t++;
      @(negedge clk);
    end
    chk("pad_done_seen", pad_done, 1);
    chk("in_ready_low_while_padding", rdy_bad, 0);
    chk("blocks", blocks, exp_blocks);
    chk("scoreboard_drained", q.size(), 0);
    chk("err", err, exp_err);
    @(negedge clk);
    chk("pad_done_one_cycle", pad_done, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_p = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_out_final", out_final, 0);
    chk("rst_blocks", blocks, 0);
    chk("rst_err", err, 0);
    chk("rst_pad_done", pad_done, 0);
    chk("rst_in_ready", in_ready, 1);

    // short message
    send_msg(3, 8'h61);
    wait_done(1, 1'b0);

    // exactly one block of data forces a full padding block
    send_msg(32, 8'h00);
    wait_done(2, 1'b0);

    // zero-length message
    in_empty = 1'b1;
    push_pad(0);
    @(posedge clk);
    #1;
    in_empty = 1'b0;
    wait_done(1, 1'b0);

    // one byte short of a block, with downstream stalling every other cycle
    toggle_en = 1'b1;
    send_msg(31, 8'h10);
    wait_done(1, 1'b0);
    toggle_en = 1'b0;

    // asynchronous reset while zero-filling
    send_msg(3, 8'h61);
    repeat (6) @(posedge clk);
    #3;
    rst_p = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_byte", out_byte, 0);
    chk("async_rst_out_final", out_final, 0);
    chk("async_rst_blocks", blocks, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_p = 1'b0;
    chk("post_rst_in_ready", in_ready, 1);
    send_msg(1, 8'hAA);
    wait_done(1, 1'b0);

    // block counter saturation in the narrow-counter instance
    send_msg(120, 8'h00);
    wait_done(4, 1'b0);
    chk("sat_blocks", s_blocks, 3);
    chk("sat_err", s_err, 1);

    // in_empty while busy is flagged but the message completes normally
    send_msg(3, 8'h30);
    repeat (5) @(posedge clk);
    #1;
    in_empty = 1'b1;
    @(posedge clk);
    #1;
    in_empty = 1'b0;
    chk("busy_empty_err", err, 1);
    wait_done(1, 1'b1);
    chk("sat_err_sticky", s_err, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
